// File: rtl/sevenseg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package sevenseg_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam int unsigned NUM_DIGITS_DEF   = 4;
  localparam int unsigned TICK_DIV_DEF     = 1000;
  localparam int unsigned BLANK_CYCLES_DEF = 2;

endpackage

// File: rtl/sevenseg_scan_tick.sv
// Slot counter: counts 0..TICK_DIV-1 and flags the wrap cycle as slot end.
module scan_tick
  import sevenseg_scan_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [$clog2(TICK_DIV)-1:0] count,
  output logic                        slot_end
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  assign slot_end = (count == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (slot_end) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed digit scanner with blanking gaps, frame-atomic value
// updates and optional leading-zero suppression. Outputs are all registered.
module sevenseg_scan
  import sevenseg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = NUM_DIGITS_DEF,
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    lz_blank,
  output logic [3:0]              digit_data,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int unsigned CW         = $clog2(TICK_DIV);
  localparam int unsigned IW         = $clog2(NUM_DIGITS);
  localparam int unsigned BLANK_LAST = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           count;
  logic                    slot_end;
  logic                    boundary;
  scan_state_t             state, state_nx;
  logic [IW-1:0]           idx, idx_nx, msnz;
  logic [4*NUM_DIGITS-1:0] shadow, active;
  logic                    pending;
  logic [3:0]              cur_digit, digit_nx;
  logic [NUM_DIGITS-1:0]   anode_nx;

  scan_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .count   (count),
    .slot_end(slot_end)
  );

  assign boundary = slot_end && (idx == IDX_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      BLANK:   if (count == CW'(BLANK_LAST)) state_nx = SHOW;
      SHOW:    if (slot_end) state_nx = BLANK;
      default: state_nx = BLANK;
    endcase
  end

  always_comb begin
    idx_nx = idx;
    if (slot_end) idx_nx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  end

  // Highest nonzero active digit; digit 0 is the floor so it is never suppressed.
  always_comb begin
    msnz = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      if (active[4*i +: 4] != 4'h0) msnz = IW'(i);
    end
  end

  assign cur_digit = active[4*idx_nx +: 4];

  // Outputs are precomputed from next-state values so the registers line up
  // with the counter/state they describe.
  always_comb begin
    anode_nx = '0;
    digit_nx = BLANK_CODE;
    if (state_nx == SHOW) begin
      anode_nx[idx_nx] = 1'b1;
      digit_nx = (lz_blank && (idx_nx > msnz)) ? BLANK_CODE : cur_digit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BLANK;
      idx        <= '0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      anode      <= '0;
      digit_data <= BLANK_CODE;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      anode      <= anode_nx;
      digit_data <= digit_nx;
      frame_done <= boundary;
      if (boundary && pending) active <= shadow;
      if (load) shadow <= value;
      if (load) begin
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with TICK_DIV=8, BLANK_CYCLES=2, NUM_DIGITS=4.
module tb_sevenseg_scan;

  localparam int unsigned ND = 4;
  localparam int unsigned TD = 8;
  localparam int unsigned BC = 2;
  localparam int unsigned FRAME = ND * TD;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [15:0]   value;
  logic          lz_blank;
  logic [3:0]    digit_data;
  logic [ND-1:0] anode;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  sevenseg_scan #(
    .NUM_DIGITS  (ND),
    .TICK_DIV    (TD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .value     (value),
    .lz_blank  (lz_blank),
    .digit_data(digit_data),
    .anode     (anode),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [15:0] exp;   // expected digit_data per slot, nibble i = digit i
  } vec_t;

  vec_t tab [8];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Starts at the negedge of a frame's first cycle; samples each cycle and
  // optionally strobes up to two loads at given cycle offsets.
  task automatic check_frame(input string tag, input logic [15:0] exp, input logic lz,
                             input logic fd, input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb, input int ncyc);
    int unsigned slot, off;
    logic [3:0]    edig;
    logic [ND-1:0] ean;
    lz_blank = lz;
    for (int c = 0; c < ncyc; c++) begin
      slot = c / TD;
      off  = c % TD;
      if (off < BC) begin
        ean  = '0;
        edig = 4'hF;
      end else begin
        ean  = ND'(1) << slot;
        edig = exp[4*slot +: 4];
      end
      chk($sformatf("%s c%0d anode", tag, c), 8'(anode), 8'(ean));
      chk($sformatf("%s c%0d digit", tag, c), 8'(digit_data), 8'(edig));
      chk($sformatf("%s c%0d frame_done", tag, c), 8'(frame_done), (c == 0) ? 8'(fd) : 8'h0);
      load = 1'b0;
      if (c == la) begin
        load  = 1'b1;
        value = va;
      end else if (c == lb) begin
        load  = 1'b1;
        value = vb;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  initial begin
    tab[0] = '{16'h1234, 1'b0, 16'h1234};
    tab[1] = '{16'h0050, 1'b1, 16'hFF50};
    tab[2] = '{16'h0050, 1'b0, 16'h0050};
    tab[3] = '{16'h00A0, 1'b1, 16'hFFA0};
    tab[4] = '{16'h0000, 1'b1, 16'hFFF0};
    tab[5] = '{16'h8007, 1'b1, 16'h8007};
    tab[6] = '{16'h0300, 1'b1, 16'hF300};
    tab[7] = '{16'hFEDC, 1'b0, 16'hFEDC};

    reset = 1'b1; load = 1'b0; value = '0; lz_blank = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset anode", 8'(anode), 8'h0);
    chk("reset digit", 8'(digit_data), 8'h0F);
    chk("reset frame_done", 8'(frame_done), 8'h0);
    reset = 1'b0;

    // Each vector is loaded mid-frame and must appear only in the following frame.
    for (int i = 0; i <= 8; i++) begin
      check_frame($sformatf("vec%0d", i),
                  (i == 0) ? 16'h0000 : tab[i-1].exp,
                  (i == 0) ? 1'b0 : tab[i-1].lz,
                  (i == 0) ? 1'b0 : 1'b1,
                  (i < 8) ? 10 : -1, (i < 8) ? tab[i].value : 16'h0,
                  -1, 16'h0, FRAME);
    end

    // Two loads in one frame: only the later one is shown.
    check_frame("dbl0", 16'hFEDC, 1'b0, 1'b1, 4, 16'h1111, 20, 16'h2222, FRAME);
    check_frame("dbl1", 16'h2222, 1'b0, 1'b1, -1, 16'h0, -1, 16'h0, FRAME);

    // Load on the boundary edge: prior shadow applies, new value one frame later.
    check_frame("bnd0", 16'h2222, 1'b0, 1'b1, 5, 16'h5678, FRAME - 1, 16'h9999, FRAME);
    check_frame("bnd1", 16'h5678, 1'b0, 1'b1, -1, 16'h0, -1, 16'h0, FRAME);
    check_frame("bnd2", 16'h9999, 1'b0, 1'b1, -1, 16'h0, -1, 16'h0, FRAME);

    // Reset during digit 2 SHOW with a load pending.
    check_frame("rst0", 16'h9999, 1'b0, 1'b1, 3, 16'h3333, -1, 16'h0, 2*TD + 5);
    chk("rst0 pre anode", 8'(anode), 8'h04);
    chk("rst0 pre digit", 8'(digit_data), 8'h09);
    reset = 1'b1;
    @(negedge clk);
    chk("rst anode", 8'(anode), 8'h0);
    chk("rst digit", 8'(digit_data), 8'h0F);
    chk("rst frame_done", 8'(frame_done), 8'h0);
    @(negedge clk);
    reset = 1'b0;
    check_frame("rst1", 16'h0000, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);
    check_frame("rst2", 16'h0000, 1'b0, 1'b1, -1, 16'h0, -1, 16'h0, FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sevenseg_scan.md
SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 2..8.
REQ-002 Parameter TICK_DIV, default 1000: clock cycles per digit slot; SHALL be greater than BLANK_CYCLES.
REQ-003 Parameter BLANK_CYCLES, default 2: anti-ghosting cycles at the start of each slot, with all anodes off.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 load  input  1  single-cycle strobe; captures value into the shadow register.
REQ-007 value  input  4*NUM_DIGITS  BCD digits; digit 0 is value[3:0] (least significant).
REQ-008 lz_blank  input  1  1 = suppress leading zeros.
REQ-009 digit_data  output  4  BCD code for the currently lit digit; feeds the downstream sevenseg decoder.
REQ-010 anode  output  NUM_DIGITS  one-hot, active-high digit enable; all-zero while blanked.
REQ-011 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 A slot counter SHALL count 0..TICK_DIV-1 and wrap to 0; the wrap cycle is the slot end.
REQ-014 FSM states:
  - BLANK: counter < BLANK_CYCLES; anode = 0; digit_data = 4'hF.
  - SHOW: remaining cycles of the slot; anode = one-hot(idx); digit_data = active digit idx.
REQ-015 FSM transitions:
  - BLANK -> SHOW when the counter reaches BLANK_CYCLES-1.
  - SHOW -> BLANK at slot end.
REQ-016 Digit index idx SHALL increment at each slot end and wrap from NUM_DIGITS-1 to 0.
REQ-017 frame_done SHALL be 1 for exactly the cycle after the edge on which idx wraps to 0.
REQ-018 On load=1, shadow <= value and pending <= 1; a later load before the frame boundary overwrites shadow.
REQ-019 At the frame boundary edge with pending=1: active <= shadow and pending <= 0.
  - A frame never displays a mix of old and new values.
REQ-020 If load coincides with the boundary edge:
  - active takes the old shadow contents;
  - shadow takes the new value;
  - pending stays 1.
REQ-021 With lz_blank=1, each digit above the most significant nonzero active digit SHALL output 4'hF (blank).
  - Digit 0 is never suppressed.
  - Its anode still asserts for its slot, so brightness stays uniform.
REQ-022 Non-BCD digit codes (10..15) SHALL pass through unchanged; the decoder blanks them.
REQ-023 Latency from load to first display of the new value: at most one frame plus one slot (NUM_DIGITS+1)*TICK_DIV cycles.

Reset
REQ-024 While reset=1, on each clock edge:
  - counter = 0, idx = 0, state = BLANK;
  - shadow = 0, active = 0, pending = 0;
  - anode = 0, digit_data = 4'hF, frame_done = 0.
REQ-025 Reset mid-slot or mid-frame SHALL discard pending data; the first cycle after release starts digit 0's BLANK phase.

Structure
REQ-026 Package sevenseg_scan_pkg SHALL hold:
  - the state enum {BLANK, SHOW};
  - constant BLANK_CODE = 4'hF;
  - the default parameter values.
REQ-027 Slot counter and slot-end strobe SHALL be a sub-module scan_tick (parameter TICK_DIV; outputs count and slot_end).
REQ-028 sevenseg_scan SHALL NOT instantiate the segment decoder; the integrator connects digit_data to the sevenseg block.

Verification (TICK_DIV=8, BLANK_CYCLES=2, NUM_DIGITS=4)
REQ-029 Reset release, no load -> repeating per slot: anode 0000 for 2 cycles, then one-hot for 6 cycles. Expected:
  - one-hot sequence 0001, 0010, 0100, 1000;
  - digit_data = 0 in SHOW;
  - frame_done every 32 cycles.
REQ-030 load value=16'h1234 mid-frame -> current frame still shows 0000; the next frame shows anode 0001:4, 0010:3, 0100:2, 1000:1.
REQ-031 lz_blank=1 with value=16'h0050 -> digits 3 and 2 output 4'hF with their anodes still asserted; digit 1 = 5; digit 0 = 0.
REQ-032 Two loads in one frame (16'h1111, then 16'h2222) -> next frame shows 2s only; 1s never displayed.
REQ-033 load 16'h9999 on the boundary edge -> the boundary applies the prior shadow; 9s appear one frame later.
REQ-034 reset asserted during a SHOW of digit 2 with a load pending -> next cycle: anode 0, digit_data 4'hF; after release, scanning restarts at digit 0 showing 0.
